// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FLUSH
  } state_e;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] insn;
  } fetch_entry_t;

  // Width of a counter that must hold every value from 0 to depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; head reads as zero when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i & (count_q != '0);
  assign do_push = push_i & ~flush_i & ((count_q != CNT_W'(DEPTH)) | do_pop);

  // NOTE: non-blocking assignments for every register so all state updates see pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; the empty-mask on data_o hides stale contents.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, issues credit-limited imem requests,
// buffers responses for decode and discards in-flight responses made stale by a redirect.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            ins_valid_o,
  output logic [XLEN-1:0] ins_pc_o,
  output logic [XLEN-1:0] ins_data_o,
  input  logic            ins_ready_i,
  output logic            busy_o
);

  localparam int CNT_W = cnt_width(FIFO_DEPTH);

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   in_use;
  logic [XLEN-1:0]  redirect_target;
  logic             fire, push, pop, stale_rsp;
  fetch_entry_t     push_entry, head_entry;
  logic             unused_pc_lsbs;

  assign redirect_target = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign unused_pc_lsbs  = ^redirect_pc_i[1:0];

  // Every granted request reserves a FIFO slot, so the buffer can never overflow.
  assign in_use     = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign imem_req_o = (state_q == RUN) & ~redirect_i & (in_use < (CNT_W + 1)'(FIFO_DEPTH));
  assign imem_addr_o = pc_q;

  assign fire      = imem_req_o & imem_gnt_i;
  assign stale_rsp = imem_rvalid_i & (discard_q != '0);
  assign push      = imem_rvalid_i & (discard_q == '0) & ~redirect_i;
  assign pop       = ins_valid_o & ins_ready_i;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    resp_pc_d     = resp_pc_q;
    discard_d     = discard_q;
    outstanding_d = outstanding_q + CNT_W'(fire) - CNT_W'(imem_rvalid_i);

    if (fire)      pc_d      = pc_q + PC_STEP;
    if (push)      resp_pc_d = resp_pc_q + PC_STEP;
    if (stale_rsp) discard_d = discard_q - CNT_W'(1);

    case (state_q)
      BOOT:    state_d = RUN;
      FLUSH:   if (stale_rsp && discard_q == CNT_W'(1)) state_d = RUN;
      default: state_d = state_q;
    endcase

    // Whatever is still in flight after this cycle belongs to the old path.
    if (redirect_i) begin
      pc_d      = redirect_target;
      resp_pc_d = redirect_target;
      discard_d = outstanding_q - CNT_W'(imem_rvalid_i);
      state_d   = (state_q == BOOT || discard_d == '0) ? RUN : FLUSH;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  assign push_entry = '{pc: resp_pc_q, insn: imem_rdata_i};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (redirect_i),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head_entry),
    .count_o (fifo_count)
  );

  assign ins_valid_o = (fifo_count != '0) & ~redirect_i;
  assign ins_pc_o    = head_entry.pc;
  assign ins_data_o  = head_entry.insn;
  assign busy_o      = (outstanding_q != '0) | (state_q == FLUSH);

  rvalid_needs_outstanding : assert property (
    @(posedge clk_i) disable iff (!rst_ni) imem_rvalid_i |-> (outstanding_q != '0)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: an in-order memory model plus a queue-based reference of the fetch stage.
module tb_fetch_ctrl;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] KEY    = 32'h5A5A_C3C3;

  logic        clk_i, rst_ni;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i, imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        ins_valid_o;
  logic [31:0] ins_pc_o, ins_data_o;
  logic        ins_ready_i;
  logic        busy_o;

  fetch_ctrl #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .ins_valid_o   (ins_valid_o),
    .ins_pc_o      (ins_pc_o),
    .ins_data_o    (ins_data_o),
    .ins_ready_i   (ins_ready_i),
    .busy_o        (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference state: requests in flight (address, stale flag, response cycle) and the buffer.
  typedef struct { logic [31:0] addr; bit stale; int due; } flight_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ibuf_t;

  flight_t     inflight[$];
  ibuf_t       ibuf[$];
  logic [31:0] log_pc[$];
  logic [31:0] grant_addr[$];
  logic [31:0] fetch_pc = RST_PC;
  bit          booted = 0;
  int          cyc = 0;

  // Stimulus knobs applied at the next falling edge.
  logic        rst_q = 1'b0, gnt_q = 1'b1, ready_q = 1'b0, redir_q = 1'b0;
  logic [31:0] redir_pc_q = '0;
  int          lat = 1;

  int n_checks = 0, n_err = 0;
  int n_grants = 0, since_rel = 0, first_req = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ KEY;
  endfunction

  function automatic int count_stale();
    int n = 0;
    foreach (inflight[i]) if (inflight[i].stale) n++;
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: condition not reached within bound (t=%0t)", name, $time);
  endtask

  task automatic check_log(input string name, input int idx, input logic [31:0] exp);
    if (idx < log_pc.size()) check(name, log_pc[idx], exp);
    else fail_now(name);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   32'(imem_req_o),  32'd0);
    check({tag, "_addr"},  imem_addr_o,      RST_PC);
    check({tag, "_valid"}, 32'(ins_valid_o), 32'd0);
    check({tag, "_pc"},    ins_pc_o,         32'd0);
    check({tag, "_data"},  ins_data_o,       32'd0);
    check({tag, "_busy"},  32'(busy_o),      32'd0);
  endtask

  task automatic model_reset();
    inflight.delete();
    ibuf.delete();
    fetch_pc = RST_PC;
    booted   = 0;
  endtask

  // One clock: drive at the falling edge, compare 1 time unit later, then advance the reference.
  task automatic step();
    flight_t e;
    logic    rv, exp_req, exp_valid, fire, pop;
    int      due;
    @(negedge clk_i);
    rst_ni = rst_q;
    if (!rst_ni) begin
      imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
      redirect_i = 1'b0; redirect_pc_i = '0;   ins_ready_i = 1'b0;
      #1;
      check_reset_outputs("rst");
      since_rel = 0; first_req = 0; redir_q = 1'b0;
      model_reset();
      cyc++;
    end else begin
      since_rel++;
      rv = (inflight.size() != 0) && (inflight[0].due == cyc);
      imem_gnt_i    = gnt_q;
      ins_ready_i   = ready_q;
      redirect_i    = redir_q;
      redirect_pc_i = redir_pc_q;
      imem_rvalid_i = rv;
      imem_rdata_i  = rv ? mem_word(inflight[0].addr) : 32'hDEAD_BEEF;
      #1;
      exp_req   = booted && (count_stale() == 0) && !redir_q && (inflight.size() + ibuf.size() < DEPTH);
      exp_valid = (ibuf.size() != 0) && !redir_q;
      check("req",   32'(imem_req_o),  32'(exp_req));
      check("addr",  imem_addr_o,      fetch_pc);
      check("valid", 32'(ins_valid_o), 32'(exp_valid));
      check("busy",  32'(busy_o),      32'(inflight.size() != 0));
      if (exp_valid) begin
        check("ins_pc",   ins_pc_o,   ibuf[0].pc);
        check("ins_data", ins_data_o, ibuf[0].data);
      end
      if (imem_req_o && gnt_q) n_grants++;
      if (imem_req_o && first_req == 0) first_req = since_rel;

      fire = exp_req && gnt_q;
      pop  = exp_valid && ready_q;
      if (pop) begin
        log_pc.push_back(ibuf[0].pc);
        void'(ibuf.pop_front());
      end
      if (rv) begin
        e = inflight.pop_front();
        if (!e.stale && !redir_q) ibuf.push_back('{pc: e.addr, data: mem_word(e.addr)});
      end
      if (redir_q) begin
        ibuf.delete();
        foreach (inflight[i]) inflight[i].stale = 1'b1;
        fetch_pc = {redir_pc_q[31:2], 2'b00};
      end
      if (fire) begin
        due = cyc + lat;
        if (inflight.size() != 0 && due <= inflight[$].due) due = inflight[$].due + 1;
        inflight.push_back('{addr: fetch_pc, stale: 1'b0, due: due});
        grant_addr.push_back(fetch_pc);
        fetch_pc = fetch_pc + 32'd4;
      end
      booted  = 1;
      redir_q = 1'b0;
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    rst_ni = 1'b0;
    redirect_i = 1'b0; redirect_pc_i = '0; imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0; imem_rdata_i = '0; ins_ready_i = 1'b0;

    // Reset, boot and backpressure: ready low from the start.
    repeat (3) step();
    rst_q = 1'b1; gnt_q = 1'b1; ready_q = 1'b0; lat = 1;
    repeat (10) step();
    check("first_req_cycle", first_req, 32'd2);
    check("bp_grants", n_grants, 32'd2);
    check("bp_req_low", 32'(imem_req_o), 32'd0);
    check("bp_head_pc", ins_pc_o, 32'h0);
    check("bp_head_data", ins_data_o, 32'h0 ^ KEY);
    check("bp_next_addr", imem_addr_o, 32'h8);
    check("bp_model_second", (ibuf.size() > 1) ? ibuf[1].pc : 32'hFFFF_FFFF, 32'h4);

    // Release backpressure: delivery resumes in program order.
    ready_q = 1'b1; log_pc.delete();
    repeat (12) step();
    check_log("seq0", 0, 32'h0);
    check_log("seq1", 1, 32'h4);
    check_log("seq2", 2, 32'h8);
    check_log("seq3", 3, 32'hC);

    // Redirect with two requests in flight and no response that cycle.
    lat = 3;
    k = 0;
    while (!(inflight.size() == 2 && inflight[0].due != cyc) && k < 40) begin step(); k++; end
    if (k >= 40) fail_now("wait_two_inflight");
    check("pre_redir_busy", 32'(busy_o), 32'd1);
    redir_q = 1'b1; redir_pc_q = 32'h0000_0100;
    log_pc.delete(); grant_addr.delete();
    step();
    check("redir_valid_drop", 32'(ins_valid_o), 32'd0);
    check("redir_req_drop", 32'(imem_req_o), 32'd0);
    k = 0;
    while (log_pc.size() < 1 && k < 40) begin step(); k++; end
    check_log("redir_first_pc", 0, 32'h100);
    check("redir_first_grant", (grant_addr.size() != 0) ? grant_addr[0] : 32'hFFFF_FFFF, 32'h100);

    // Redirect on the cycle the first of two responses returns: only one left to discard.
    k = 0;
    while (!(inflight.size() == 2 && inflight[0].due == cyc) && k < 40) begin step(); k++; end
    if (k >= 40) fail_now("wait_rvalid_inflight");
    redir_q = 1'b1; redir_pc_q = 32'h0000_0200;
    log_pc.delete();
    step();
    check("discard_one", count_stale(), 32'd1);
    k = 0;
    while (log_pc.size() < 2 && k < 40) begin step(); k++; end
    check_log("rv_redir_pc0", 0, 32'h200);
    check_log("rv_redir_pc1", 1, 32'h204);

    // Redirect to the top word; low address bits are ignored and the PC wraps.
    lat = 1;
    redir_q = 1'b1; redir_pc_q = 32'hFFFF_FFFE;
    log_pc.delete();
    step();
    k = 0;
    while (log_pc.size() < 2 && k < 40) begin step(); k++; end
    check_log("wrap_pc0", 0, 32'hFFFF_FFFC);
    check_log("wrap_pc1", 1, 32'h0000_0000);

    // Back-to-back redirects while flushing, then a mixed stall/latency phase.
    lat = 3;
    repeat (3) step();
    redir_q = 1'b1; redir_pc_q = 32'h0000_1000; step();
    redir_q = 1'b1; redir_pc_q = 32'h0000_2000; log_pc.delete(); step();
    k = 0;
    while (log_pc.size() < 1 && k < 40) begin step(); k++; end
    check_log("double_redir_pc", 0, 32'h2000);
    repeat (80) begin
      gnt_q   = 1'($urandom_range(0, 1));
      ready_q = ($urandom_range(0, 3) != 0);
      lat     = $urandom_range(1, 3);
      if ($urandom_range(0, 11) == 0) begin
        redir_q = 1'b1; redir_pc_q = $urandom;
      end
      step();
    end

    // Asynchronous reset in the middle of a burst.
    gnt_q = 1'b1; ready_q = 1'b1; lat = 2;
    k = 0;
    while (inflight.size() == 0 && k < 40) begin step(); k++; end
    check("pre_reset_busy", 32'(busy_o), 32'd1);
    #1 rst_ni = 1'b0; rst_q = 1'b0;
    #1 check_reset_outputs("async");
    model_reset();
    repeat (2) step();
    rst_q = 1'b1; log_pc.delete();
    k = 0;
    while (log_pc.size() < 2 && k < 40) begin step(); k++; end
    check_log("restart_pc0", 0, RST_PC);
    check_log("restart_pc1", 1, RST_PC + 32'd4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
